// File: rtl/iter_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MD_* : opcode encodings on the 3-bit op port (6 and 7 are reserved no-ops)
//   md_state_e : FSM state encoding used by iter_muldiv
package iter_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } md_state_e;

endpackage

// File: rtl/iter_muldiv_step.sv
// Combinational single radix-2 step of the iterative multiply/divide datapath.
// Operates on unsigned magnitudes; sign handling lives in the top module.
//   is_div     : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi     : multiply partial product P (low WIDTH bits) / divide remainder
//   acc_lo     : multiplier (shifted out LSB-first) / dividend-quotient register
//   opnd       : multiplicand / divisor
//   acc_hi_nxt : next acc_hi
//   acc_lo_nxt : next acc_lo
module iter_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+2:0] trial;
    logic             q_bit;
    logic             unused_trial_bit;

    always_comb begin
        addend    = acc_lo[0] ? opnd : '0;
        mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + {1'b0, addend};
        // Remainder shifted left with the next dividend bit; the extra top bit
        // keeps the trial subtraction's sign bit clean.
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {3'b000, opnd};
        q_bit     = ~trial[WIDTH+2];

        if (is_div) begin
            acc_hi_nxt = q_bit ? trial[WIDTH:0] : rem_shift[WIDTH:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], q_bit};
        end else begin
            // {P, multiplier} shifts right by one after the conditional add.
            acc_hi_nxt = {1'b0, mul_sum[WIDTH:1]};
            acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Never set once a trial subtract succeeds: the remainder stays below the divisor.
    assign unused_trial_bit = trial[WIDTH+1];

endmodule

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (WIDTH radix-2 steps + one sign-fixup
// cycle); MTHI/MTLO write HI/LO directly on the next edge.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : issue op/a/b this cycle (ignored while busy)
//   op       : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b     : rs / rt operands, sampled only in the start cycle
//   flush    : abort the in-flight op, or suppress this cycle's start
//   busy     : op in progress (stall source for HI/LO readers)
//   done     : one-cycle pulse in the cycle HI/LO take a mul/div result
//   hi, lo   : architectural HI/LO registers
module iter_muldiv
    import iter_muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             is_div_q;
    logic             neg_res_q;  // negate product / quotient
    logic             neg_rem_q;  // negate remainder (dividend was negative)
    logic             div0_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   acc_hi_nxt;
    logic [WIDTH-1:0] acc_lo_nxt;

    // Issue-time operand preparation
    logic             accept_md;
    logic             signed_op;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Result fixup
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    iter_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div     (is_div_q),
        .acc_hi     (acc_hi_q),
        .acc_lo     (acc_lo_q),
        .opnd       (opnd_q),
        .acc_hi_nxt (acc_hi_nxt),
        .acc_lo_nxt (acc_lo_nxt)
    );

    always_comb begin
        accept_md = start && !flush && (op <= MD_DIVU);
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        sa        = signed_op && a[WIDTH-1];
        sb        = signed_op && b[WIDTH-1];
        mag_a     = sa ? (~a + 1'b1) : a;
        mag_b     = sb ? (~b + 1'b1) : b;
    end

    always_comb begin
        prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
        quo      = acc_lo_q;
        rem      = acc_hi_q[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero yields an all-ones quotient regardless of signs; the
            // remainder magnitude is |a| and regains a's sign below.
            fix_lo = div0_q ? '1 : (neg_res_q ? (~quo + 1'b1) : quo);
            fix_hi = neg_rem_q ? (~rem + 1'b1) : rem;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept_md) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                busy    = 1'b1;
                done    = !flush;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept_md) begin
                        cnt_q     <= CNT_W'(WIDTH);
                        acc_hi_q  <= '0;
                        is_div_q  <= op[1];
                        neg_res_q <= sa ^ sb;
                        neg_rem_q <= sa;
                        div0_q    <= (b == '0);
                        acc_lo_q  <= op[1] ? mag_a : mag_b;
                        opnd_q    <= op[1] ? mag_b : mag_a;
                    end else if (start && !flush && (op == MD_MTHI)) begin
                        hi_q <= a;
                    end else if (start && !flush && (op == MD_MTLO)) begin
                        lo_q <= a;
                    end
                end
                StRun: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else begin
                        acc_hi_q <= acc_hi_nxt;
                        acc_lo_q <= acc_lo_nxt;
                        cnt_q    <= cnt_q - CNT_W'(1);
                    end
                end
                StFix: begin
                    if (!flush) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv (WIDTH=32): table-driven vectors, a
// reference-model random pass, and hand-written flush/reset/MTHI/MTLO sequences.
module tb_iter_muldiv;
    import iter_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done;

    iter_muldiv #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    vec_t        tbl[12];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        int          sx, sy;
        longint      p;
        logic [63:0] pu;
        sx = x;
        sy = y;
        case (o)
            MD_MULT: begin
                p = longint'(sx) * longint'(sy);
                {r.hi, r.lo} = p;
            end
            MD_MULTU: begin
                pu = {32'b0, x} * {32'b0, y};
                {r.hi, r.lo} = pu;
            end
            MD_DIV: begin
                if (y == 32'd0) begin
                    r.lo = '1;
                    r.hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.lo = x;
                    r.hi = '0;
                end else begin
                    r.lo = sx / sy;
                    r.hi = sx % sy;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    r.lo = '1;
                    r.hi = x;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    // Issue one mul/div op, optionally poke a second start mid-run, and check
    // latency, busy duration and the scoreboarded HI/LO result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input bit poke);
        res_t e;
        int   cyc;
        int   busy_cyc;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back('{hi: eh, lo: el});
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        busy_cyc = 0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            if (busy) busy_cyc++;
            start = poke && (cyc == 5);
            if (start) begin
                op = MD_MULT;
                a  = 32'd1;
                b  = 32'd1;
            end
            if (done) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_cycle", 64'(cyc), 64'd33);
        chk("busy_cycles", 64'(busy_cyc), 64'd33);
        e = sb.pop_front();
        @(negedge clk);
        chk("result_hi", hi, e.hi);
        chk("result_lo", lo, e.lo);
        chk("idle_after_done", {busy, done}, 2'b00);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          any_done;
        res_t        m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        tbl[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3};
        tbl[4]  = '{MD_DIVU,  32'd1234,      32'd0,        32'h0000_04D2, 32'hFFFF_FFFF};
        tbl[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        tbl[6]  = '{MD_MULT,  32'd5,         32'd6,        32'd0,         32'h0000_001E};
        tbl[7]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        tbl[8]  = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
        tbl[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[10] = '{MD_MULTU, 32'h1234_5678, 32'h10,       32'd1,         32'h2345_6780};
        tbl[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy_done", {busy, done}, 2'b00);
        rst = 1'b0;

        // Vector 3 gets a second start injected while busy; it must be ignored.
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, i == 3);
        end

        // Flush mid-RUN together with a second start: flush wins, no done, HI/LO kept.
        @(negedge clk);
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd5;
        b     = 32'd6;
        @(negedge clk);
        start    = 1'b0;
        any_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            any_done |= done;
            @(negedge clk);
        end
        any_done |= done;
        start = 1'b1;
        flush = 1'b1;
        op    = MD_DIVU;
        a     = 32'd7;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            any_done |= done;
            @(negedge clk);
        end
        chk("flush_no_done", any_done, 1'b0);
        chk("flush_busy_stays_low", busy, 1'b0);
        chk("flush_hi_kept", hi, last_hi);
        chk("flush_lo_kept", lo, last_lo);

        // Flush in the FIX cycle: done suppressed, HI/LO not written.
        @(negedge clk);
        start = 1'b1;
        op    = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fix_flush_busy", busy, 1'b1);
        chk("fix_flush_done", done, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        chk("fix_flush_idle", busy, 1'b0);
        chk("fix_flush_hi_kept", hi, last_hi);
        chk("fix_flush_lo_kept", lo, last_lo);

        // MTHI, flushed MTLO, MTLO, reserved op.
        @(negedge clk);
        start = 1'b1;
        op    = MD_MTHI;
        a     = 32'hAAAA_5555;
        #1;
        chk("mthi_no_busy", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'hAAAA_5555);
        chk("mthi_busy", {busy, done}, 2'b00);
        start = 1'b1;
        flush = 1'b1;
        op    = MD_MTLO;
        a     = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("mtlo_flushed", lo, last_lo);
        start = 1'b1;
        op    = MD_MTLO;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h1357_9BDF);
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0BAD_0BAD;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("reserved_op_idle", {busy, done}, 2'b00);
        chk("reserved_op_hilo", {hi, lo}, {32'hAAAA_5555, 32'h1357_9BDF});

        // Asynchronous reset mid-RUN clears HI/LO and busy before any edge.
        @(negedge clk);
        start = 1'b1;
        op    = MD_MULTU;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        chk("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        last_hi = '0;
        last_lo = '0;
        run_op(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);

        // Random pass against the reference model.
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            m  = model(ro, ra, rb);
            run_op(ro, ra, rb, m.hi, m.lo, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
